// File: rtl/load_store_unit.sv
// Purpose : RV32I load/store memory stage; lane steering, byte enables, load extension,
//           misalignment / illegal-width detection and bus timeout over a req/ack data bus.
// Latency : start in cycle 0 -> mem_req from cycle 1; ack in cycle k -> done in cycle k+1.
// Backpr. : no queueing; start is only sampled in IDLE, stall holds the datapath while busy.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   start/op_store/funct3/addr/   request from the datapath (address is the ALU result,
//   store_data                    store_data is rs2)
//   mem_req/mem_we/mem_addr/      word-wide bus request, held stable while in REQ
//   mem_be/mem_wdata
//   mem_ack/mem_rdata             single-cycle acknowledge, read word valid with the ack
//   load_data                     extended load result, held until the next good load
//   done/error                    one-cycle completion / failure pulses
//   stall                         hold PC and suppress writeback
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        op_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] load_data,
  output logic        done,
  output logic        error,
  output logic        stall
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // The counter holds the number of REQ cycles already completed, so the last
  // permitted REQ cycle is the one where it equals TIMEOUT_CYCLES-1.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_cnt;
  logic [2:0]  r_f3;
  logic [1:0]  r_off;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [3:0]  r_mem_be;
  logic [31:0] r_mem_wdata;
  logic [31:0] r_load_data;
  logic        r_done;
  logic        r_error;

  logic        w_legal;
  logic        w_aligned;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic        w_launch;
  logic        w_capture;
  logic        w_done_nxt;
  logic        w_err_nxt;
  logic        w_req_end;
  logic [31:0] w_shifted;
  logic [31:0] w_ext;

  // Request decode: width from funct3[1:0], signedness from funct3[2] (loads only).
  always_comb begin
    w_legal   = 1'b0;
    w_aligned = 1'b0;
    w_be      = 4'b0000;
    w_wdata   = 32'h0;
    case (funct3[1:0])
      2'b00: begin
        w_aligned = 1'b1;
        w_be      = 4'b0001 << addr[1:0];
        w_wdata   = {4{store_data[7:0]}};
      end
      2'b01: begin
        w_aligned = ~addr[0];
        w_be      = 4'b0011 << addr[1:0];
        w_wdata   = {2{store_data[15:0]}};
      end
      2'b10: begin
        w_aligned = (addr[1:0] == 2'b00);
        w_be      = 4'b1111;
        w_wdata   = store_data;
      end
      default: begin
        w_aligned = 1'b0;
      end
    endcase
    if (op_store) begin
      w_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    end else begin
      w_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                (funct3 == 3'b100) || (funct3 == 3'b101);
      w_wdata = 32'h0;
    end
  end

  // Load extraction: move the addressed lane down to bit 0, then extend.
  assign w_shifted = mem_rdata >> {r_off, 3'b000};

  always_comb begin
    w_ext = w_shifted;
    case (r_f3)
      3'b000:  w_ext = {{24{w_shifted[7]}}, w_shifted[7:0]};
      3'b001:  w_ext = {{16{w_shifted[15]}}, w_shifted[15:0]};
      3'b100:  w_ext = {24'h0, w_shifted[7:0]};
      3'b101:  w_ext = {16'h0, w_shifted[15:0]};
      default: w_ext = w_shifted;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and transaction events
  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    w_capture   = 1'b0;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    w_req_end   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (w_legal && w_aligned) begin
            w_launch    = 1'b1;
            w_state_nxt = ST_REQ;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      ST_REQ: begin
        // An ack in the final allowed cycle still completes the access.
        if (mem_ack) begin
          w_state_nxt = ST_RESP;
          w_done_nxt  = 1'b1;
          w_capture   = ~r_mem_we;
          w_req_end   = 1'b1;
        end else if (r_cnt == TO_LAST) begin
          w_state_nxt = ST_IDLE;
          w_err_nxt   = 1'b1;
          w_req_end   = 1'b1;
        end
      end
      ST_RESP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Bus-side and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'h0;
      r_mem_be    <= 4'b0000;
      r_mem_wdata <= 32'h0;
      r_load_data <= 32'h0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_cnt       <= 8'h0;
      r_f3        <= 3'b000;
      r_off       <= 2'b00;
    end else begin
      r_done  <= w_done_nxt;
      r_error <= w_err_nxt;
      if (w_launch) begin
        r_mem_req   <= 1'b1;
        r_mem_we    <= op_store;
        r_mem_addr  <= {addr[31:2], 2'b00};
        r_mem_be    <= w_be;
        r_mem_wdata <= w_wdata;
        r_f3        <= funct3;
        r_off       <= addr[1:0];
      end else if (w_req_end) begin
        r_mem_req <= 1'b0;
      end
      r_cnt <= (r_state == ST_REQ) ? r_cnt + 8'd1 : 8'h0;
      if (w_capture) begin
        r_load_data <= w_ext;
      end
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_be    = r_mem_be;
  assign mem_wdata = r_mem_wdata;
  assign load_data = r_load_data;
  assign done      = r_done;
  assign error     = r_error;

  // Low in RESP on purpose: writeback happens in the done cycle.
  assign stall = ((r_state == ST_IDLE) && start && w_legal && w_aligned) ||
                 (r_state == ST_REQ);

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        op_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] load_data;
  logic        done;
  logic        error;
  logic        stall;

  int errors = 0;
  int checks = 0;

  // observations gathered by run_op
  int          o_done_cyc, o_err_cyc, o_done_cnt, o_err_cnt, o_req_cnt, o_req_rises;
  bit [31:0]   o_stall_mask;
  bit          o_unstable;
  bit          o_we;
  bit [31:0]   o_addr, o_wdata, o_load;
  bit [3:0]    o_be;

  // reference-model state
  bit [31:0]   m_last_load;

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .op_store(op_store), .funct3(funct3),
    .addr(addr), .store_data(store_data), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .load_data(load_data), .done(done), .error(error),
    .stall(stall)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic bit m_legal(input bit st, input bit [2:0] f);
    if (st) return (f <= 3'd2);
    return (f <= 3'd2) || (f == 3'd4) || (f == 3'd5);
  endfunction

  function automatic int m_size(input bit [2:0] f);
    return 1 << f[1:0];
  endfunction

  function automatic bit m_aligned(input bit [2:0] f, input bit [31:0] a);
    return (a % m_size(f)) == 0;
  endfunction

  function automatic bit [3:0] m_be(input bit [2:0] f, input bit [31:0] a);
    int n;
    n = m_size(f);
    return 4'(((1 << n) - 1) << (a % 4));
  endfunction

  function automatic bit [31:0] m_wdata(input bit st, input bit [2:0] f, input bit [31:0] d);
    bit [31:0] b;
    if (!st) return 32'h0;
    case (m_size(f))
      1: begin b = d & 32'hFF;   return b * 32'h0101_0101; end
      2: begin b = d & 32'hFFFF; return b * 32'h0001_0001; end
      default: return d;
    endcase
  endfunction

  function automatic bit [31:0] m_load(input bit [2:0] f, input bit [31:0] a, input bit [31:0] rd);
    longint v;
    int     bits;
    bits = m_size(f) * 8;
    v = rd;
    v = (v >> (8 * (a % 4))) & ((64'd1 << bits) - 1);
    if (f[2] == 1'b0 && bits < 32 && v >= (longint'(1) << (bits - 1)))
      v = v - (longint'(1) << bits);
    return 32'(v);
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      mem_ack = 1'b0;
    end
  endtask

  // Issues one request in cycle 0 and records what the bus does until done/error.
  // ack_cyc = cycle in which mem_ack is driven (0 = never); start stays high
  // (with perturbed fields) through cycle hold_start to exercise "ignored" starts.
  task automatic run_op(input bit st, input bit [2:0] f, input bit [31:0] a,
                        input bit [31:0] d, input int ack_cyc, input bit [31:0] rd,
                        input int hold_start);
    bit prev_req;
    o_done_cyc = -1; o_err_cyc = -1; o_done_cnt = 0; o_err_cnt = 0;
    o_req_cnt = 0; o_req_rises = 0; o_stall_mask = 0; o_unstable = 0;
    o_we = 0; o_addr = 0; o_be = 0; o_wdata = 0;
    prev_req = 0;
    @(posedge clk); #1;
    start = 1'b1; op_store = st; funct3 = f; addr = a; store_data = d;
    mem_ack = 1'b0; mem_rdata = rd;
    for (int c = 0; c < 30; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        start = (c <= hold_start);
        if (start) begin
          op_store   = ~st;
          addr       = a ^ 32'h0000_0F00;
          store_data = ~d;
        end
        mem_ack = (c == ack_cyc);
      end
      @(negedge clk);
      if (stall) o_stall_mask[c] = 1'b1;
      if (mem_req) begin
        if (o_req_cnt == 0) begin
          o_we = mem_we; o_addr = mem_addr; o_be = mem_be; o_wdata = mem_wdata;
        end else if ({o_we, o_addr, o_be, o_wdata} != {mem_we, mem_addr, mem_be, mem_wdata}) begin
          o_unstable = 1'b1;
        end
        o_req_cnt++;
        if (!prev_req) o_req_rises++;
      end
      prev_req = mem_req;
      if (done) begin
        o_done_cnt++;
        if (o_done_cyc < 0) o_done_cyc = c;
      end
      if (error) begin
        o_err_cnt++;
        if (o_err_cyc < 0) o_err_cyc = c;
      end
      if (done || error) break;
    end
    o_load = load_data;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1; start = 1'b0; op_store = 1'b0; funct3 = 3'b000; addr = 32'h0;
    store_data = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({mem_req, mem_we, done, error, stall} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got req/we/done/err/stall=%b required 00000",
               {mem_req, mem_we, done, error, stall});
    end
    checks++;
    if ({mem_addr, mem_be, mem_wdata, load_data} !== {32'h0, 4'h0, 32'h0, 32'h0}) begin
      errors++;
      $display("FAIL reset_data: got addr=%h be=%b wdata=%h load=%h required all zero",
               mem_addr, mem_be, mem_wdata, load_data);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    m_last_load = 32'h0;
  endtask

  task automatic test_reset_mid_req;
    int bad;
    @(posedge clk); #1;            // cycle 0
    start = 1'b1; op_store = 1'b1; funct3 = 3'b010; addr = 32'h100; store_data = 32'hCAFE_F00D;
    @(posedge clk); #1;            // cycle 1
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_req_up: mem_req=%b required 1", mem_req);
    end
    @(posedge clk); #1;            // cycle 2
    rst = 1'b1;
    @(posedge clk); #1;            // cycle 3
    rst = 1'b0;
    @(negedge clk);
    bad = 0;
    if (mem_req !== 1'b0 || done !== 1'b0 || error !== 1'b0 || stall !== 1'b0) bad = 1;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rst_mid_req_clear: req=%b done=%b err=%b stall=%b required 0000",
               mem_req, done, error, stall);
    end
    m_last_load = 32'h0;
    // new request accepted in cycle 4
    run_op(1'b1, 3'b010, 32'h104, 32'h1111_2222, 1, 32'h0, 0);
    checks++;
    if (o_done_cyc != 2 || o_err_cnt != 0 || o_req_cnt != 1) begin
      errors++;
      $display("FAIL rst_mid_restart: done_cyc=%0d err=%0d req_cycles=%0d required 2/0/1",
               o_done_cyc, o_err_cnt, o_req_cnt);
    end
    idle(2);
  endtask

  task automatic test_store_byte;
    run_op(1'b1, 3'b000, 32'h0000_0103, 32'h1234_56A5, 3, 32'h0, 0);
    checks++;
    if ({o_we, o_addr, o_be, o_wdata} !== {1'b1, 32'h100, 4'b1000, 32'hA5A5_A5A5}) begin
      errors++;
      $display("FAIL sb_bus: we=%b addr=%h be=%b wdata=%h required 1 00000100 1000 a5a5a5a5",
               o_we, o_addr, o_be, o_wdata);
    end
    checks++;
    if (o_done_cyc != 4 || o_req_cnt != 3 || o_unstable) begin
      errors++;
      $display("FAIL sb_timing: done_cyc=%0d req_cycles=%0d unstable=%0d required 4/3/0",
               o_done_cyc, o_req_cnt, o_unstable);
    end
    checks++;
    if (o_stall_mask !== 32'h0000_000F) begin
      errors++;
      $display("FAIL sb_stall: mask=%h required 0000000f", o_stall_mask);
    end
    checks++;
    if (o_load !== m_last_load) begin
      errors++;
      $display("FAIL sb_load_kept: load_data=%h required %h", o_load, m_last_load);
    end
    idle(2);
  endtask

  task automatic test_load_extend;
    run_op(1'b0, 3'b000, 32'h202, 32'h0, 1, 32'h80FF_7F01, 0);
    checks++;
    if (o_load !== 32'hFFFF_FFFF || o_done_cyc != 2) begin
      errors++;
      $display("FAIL lb_sign: load=%h done_cyc=%0d required ffffffff/2", o_load, o_done_cyc);
    end
    checks++;
    if ({o_we, o_addr, o_be, o_wdata} !== {1'b0, 32'h200, 4'b0100, 32'h0}) begin
      errors++;
      $display("FAIL lb_bus: we=%b addr=%h be=%b wdata=%h required 0 00000200 0100 0",
               o_we, o_addr, o_be, o_wdata);
    end
    run_op(1'b0, 3'b101, 32'h202, 32'h0, 2, 32'h80FF_7F01, 0);
    checks++;
    if (o_load !== 32'h0000_80FF) begin
      errors++;
      $display("FAIL lhu_zero: load=%h required 000080ff", o_load);
    end
    m_last_load = 32'h0000_80FF;
    idle(2);
  endtask

  task automatic test_misaligned;
    run_op(1'b0, 3'b010, 32'h105, 32'h0, 1, 32'hDEAD_BEEF, 0);
    checks++;
    if (o_err_cyc != 1 || o_done_cnt != 0 || o_req_cnt != 0) begin
      errors++;
      $display("FAIL misaligned_err: err_cyc=%0d done=%0d req_cycles=%0d required 1/0/0",
               o_err_cyc, o_done_cnt, o_req_cnt);
    end
    checks++;
    if (o_stall_mask !== 32'h0 || o_load !== m_last_load) begin
      errors++;
      $display("FAIL misaligned_side: stall_mask=%h load=%h required 0/%h",
               o_stall_mask, o_load, m_last_load);
    end
    idle(2);
  endtask

  task automatic test_timeout;
    run_op(1'b0, 3'b010, 32'h40, 32'h0, 0, 32'h1234_5678, 0);
    checks++;
    if (o_req_cnt != TO || o_err_cyc != TO + 1 || o_done_cnt != 0) begin
      errors++;
      $display("FAIL timeout_abort: req_cycles=%0d err_cyc=%0d done=%0d required %0d/%0d/0",
               o_req_cnt, o_err_cyc, o_done_cnt, TO, TO + 1);
    end
    checks++;
    if (o_load !== m_last_load || o_stall_mask !== 32'h1F) begin
      errors++;
      $display("FAIL timeout_side: load=%h stall_mask=%h required %h/0000001f",
               o_load, o_stall_mask, m_last_load);
    end
    idle(2);
    run_op(1'b0, 3'b010, 32'h40, 32'h0, TO, 32'h1234_5678, 0);
    checks++;
    if (o_done_cyc != TO + 1 || o_err_cnt != 0 || o_load !== 32'h1234_5678) begin
      errors++;
      $display("FAIL timeout_ack_wins: done_cyc=%0d err=%0d load=%h required %0d/0/12345678",
               o_done_cyc, o_err_cnt, o_load, TO + 1);
    end
    m_last_load = 32'h1234_5678;
    idle(2);
  endtask

  task automatic test_back_to_back;
    int r1, d1, u1, r2, d2, c2, seen;
    run_op(1'b1, 3'b010, 32'h80, 32'h0BAD_F00D, 2, 32'h0, 2);
    r1 = o_req_rises; d1 = o_done_cnt; u1 = o_unstable;
    checks++;
    if (o_addr !== 32'h80 || o_wdata !== 32'h0BAD_F00D || o_be !== 4'hF || o_we !== 1'b1) begin
      errors++;
      $display("FAIL b2b_sw_bus: addr=%h wdata=%h be=%b we=%b required 80/0badf00d/1111/1",
               o_addr, o_wdata, o_be, o_we);
    end
    run_op(1'b0, 3'b010, 32'h84, 32'h0, 1, 32'h5A5A_0F0F, 0);
    r2 = o_req_rises; d2 = o_done_cnt; c2 = o_done_cyc;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      start = 1'b0; mem_ack = 1'b0;
      @(negedge clk);
      if (mem_req || done || error) seen++;
    end
    checks++;
    if (r1 + r2 != 2 || d1 != 1 || d2 != 1 || seen != 0 || u1 != 0) begin
      errors++;
      $display("FAIL b2b_count: txns=%0d dones=%0d/%0d extra=%0d unstable=%0d required 2 1/1 0 0",
               r1 + r2, d1, d2, seen, u1);
    end
    checks++;
    if (o_load !== 32'h5A5A_0F0F || c2 != 2) begin
      errors++;
      $display("FAIL b2b_lw: load=%h done_cyc=%0d required 5a5a0f0f/2", o_load, c2);
    end
    m_last_load = 32'h5A5A_0F0F;
  endtask

  task automatic test_random;
    bit        st;
    bit [2:0]  f;
    bit [31:0] a, d, rd;
    int        ack;
    bit        ok;
    bit [31:0] e_load;
    for (int it = 0; it < 60; it++) begin
      st  = 1'($urandom_range(0, 1));
      f   = 3'($urandom_range(0, 7));
      a   = $urandom;
      if ($urandom_range(0, 1) == 1) a = a & ~(32'd1 << $urandom_range(0, 1));
      d   = $urandom;
      rd  = $urandom;
      ack = $urandom_range(1, TO + 2);
      ok  = m_legal(st, f) && m_aligned(f, a);
      run_op(st, f, a, d, ack, rd, 0);
      if (!ok) begin
        checks++;
        if (o_err_cyc != 1 || o_req_cnt != 0 || o_stall_mask != 0 || o_load !== m_last_load) begin
          errors++;
          $display("FAIL rnd_reject it=%0d st=%0d f=%0d a=%h: err_cyc=%0d req=%0d stall=%h load=%h required 1/0/0/%h",
                   it, st, f, a, o_err_cyc, o_req_cnt, o_stall_mask, o_load, m_last_load);
        end
      end else if (ack <= TO) begin
        e_load = st ? m_last_load : m_load(f, a, rd);
        checks++;
        if ({o_we, o_addr, o_be, o_wdata} !== {st, a & 32'hFFFF_FFFC, m_be(f, a), m_wdata(st, f, d)}) begin
          errors++;
          $display("FAIL rnd_bus it=%0d: we=%b addr=%h be=%b wdata=%h required %b %h %b %h",
                   it, o_we, o_addr, o_be, o_wdata, st, a & 32'hFFFF_FFFC, m_be(f, a), m_wdata(st, f, d));
        end
        checks++;
        if (o_done_cyc != ack + 1 || o_err_cnt != 0 || o_req_cnt != ack || o_unstable ||
            o_stall_mask !== 32'((64'd1 << (ack + 1)) - 1)) begin
          errors++;
          $display("FAIL rnd_timing it=%0d: done_cyc=%0d err=%0d req=%0d stall=%h required %0d/0/%0d",
                   it, o_done_cyc, o_err_cnt, o_req_cnt, o_stall_mask, ack + 1, ack);
        end
        checks++;
        if (o_load !== e_load) begin
          errors++;
          $display("FAIL rnd_load it=%0d f=%0d a=%h rd=%h: load=%h required %h",
                   it, f, a, rd, o_load, e_load);
        end
        m_last_load = e_load;
      end else begin
        checks++;
        if (o_err_cyc != TO + 1 || o_done_cnt != 0 || o_req_cnt != TO || o_load !== m_last_load) begin
          errors++;
          $display("FAIL rnd_timeout it=%0d: err_cyc=%0d done=%0d req=%0d load=%h required %0d/0/%0d/%h",
                   it, o_err_cyc, o_done_cnt, o_req_cnt, o_load, TO + 1, TO, m_last_load);
        end
      end
      idle($urandom_range(0, 2));
    end
  endtask

  initial begin
    test_reset;
    test_reset_mid_req;
    test_store_byte;
    test_load_extend;
    test_misaligned;
    test_timeout;
    test_back_to_back;
    test_random;
    idle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
